// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder: FSM state
// encoding, default widths and the wait-state counter width.
package mips_mem_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int ADDR_BITS_DEF   = 6;
  localparam int CNT_WIDTH       = 4;
  localparam int WAIT_CYCLES_MAX = (1 << CNT_WIDTH) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // A word access is misaligned when either byte-offset bit is set.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// mem_array_64x32: word storage with synchronous write and a registered
// read port. Both ports only act on the commit edge chosen by the
// responder FSM. The array itself has no reset; only the read register
// is cleared so rdata starts from a known value.
module mem_array_64x32 #(
  parameter int ADDR_BITS  = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_BITS-1:0]  idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Store port: a write is suppressed while reset is held so an access
  // interrupted by reset can never reach the array.
  always_ff @(posedge clk) begin
    if (wr_en && rst) begin
      mem_q[idx] <= wdata;
    end
  end

  // Load port: rdata keeps its value until the next committed load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-port responder for the MIPS MEM stage.
// Accepts one LW/SW per handshake while ready is high, waits WAIT_CYCLES
// edges, commits the access to the 64x32 array and pulses done.
// Optional build macro DATA_MEM_ALIGN_CHECK_EN: misaligned accesses are
// rejected at commit (no write, rdata unchanged) and flagged with err.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait_cycles
    $error("data_mem_responder: WAIT_CYCLES must be within 0..15");
  end

  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
    CNT_WIDTH'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  mem_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_BITS-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;

  logic                  commit;
  logic                  acc_we;
  logic [ADDR_BITS-1:0]  acc_idx;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_misalign;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_BITS-1:0]  addr_idx;
  logic                  unused_addr;

  // Upper address bits fall outside the array, so the address wraps.
  assign addr_idx = addr[ADDR_BITS+1:2];

`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic err_q, err_d;
  assign unused_addr = ^addr[31:ADDR_BITS+2];
`else
  assign unused_addr = ^{addr[31:ADDR_BITS+2], addr[1:0]};
`endif

  // The access being committed: live inputs when committing straight
  // from IDLE (zero wait states), otherwise the copy latched at acceptance.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = we;
      acc_idx   = addr_idx;
      acc_wdata = wdata;
`ifdef DATA_MEM_ALIGN_CHECK_EN
      acc_misalign = is_misaligned(addr[1:0]);
`else
      acc_misalign = 1'b0;
`endif
    end else begin
      acc_we    = we_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
`ifdef DATA_MEM_ALIGN_CHECK_EN
      acc_misalign = misalign_q;
`else
      acc_misalign = 1'b0;
`endif
    end
  end

  // Next-state logic: accept in IDLE, count wait states, commit, then
  // spend exactly one cycle in DONE before returning to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    commit  = 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    misalign_d = misalign_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          idx_d   = addr_idx;
          wdata_d = wdata;
          ready_d = 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
          misalign_d = is_misaligned(addr[1:0]);
`endif
          if (HAS_WAIT) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            commit  = 1'b1;
            state_d = DONE;
            done_d  = 1'b1;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            err_d = acc_misalign;
`endif
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = DONE;
          done_d  = 1'b1;
`ifdef DATA_MEM_ALIGN_CHECK_EN
          err_d = acc_misalign;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State, counter, latched request and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef DATA_MEM_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
      err_q      <= err_d;
`endif
    end
  end

  // A rejected access commits nothing: no write and rdata left untouched.
  assign wr_en = commit &  acc_we & ~acc_misalign;
  assign rd_en = commit & ~acc_we & ~acc_misalign;

  mem_array_64x32 #(
    .ADDR_BITS  (ADDR_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (rdata)
  );

  assign ready = ready_q;
  assign done  = done_q;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. A stimulus process issues accesses and
// pushes the expected response into a queue; a monitor pops and compares
// whenever done is seen. A second instance with zero wait states checks
// back-to-back handshakes with req held high.
module tb_data_mem_responder;

  localparam int WC       = 2;
  localparam int MAX_WAIT = 100;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          issue_cycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, err;
  logic [31:0] rdata;

  logic        req0 = 1'b0;
  logic        we0 = 1'b0;
  logic [31:0] addr0 = '0;
  logic [31:0] wdata0 = '0;
  logic        ready0, done0, err0;
  logic [31:0] rdata0;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cycle_cnt = 0;

  exp_t        exp_q[$];
  logic [31:0] model_mem [64];
  logic [31:0] model_rdata = '0;

  data_mem_responder #(.WAIT_CYCLES(WC)) dut (
    .clk (clk), .rst (rst), .req (req), .we (we), .addr (addr), .wdata (wdata),
    .ready (ready), .done (done), .rdata (rdata), .err (err)
  );

  data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk (clk), .rst (rst), .req (req0), .we (we0), .addr (addr0), .wdata (wdata0),
    .ready (ready0), .done (done0), .rdata (rdata0), .err (err0)
  );

  // Free-running clock and cycle counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding access.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("rdata", rdata, e.exp_rdata);
        check_output("err", {31'b0, err}, {31'b0, e.exp_err});
        check_output("latency", 32'(cycle_cnt - e.issue_cycle), 32'(WC + 1));
        check_output("ready_at_done", {31'b0, ready}, 32'd0);
      end
    end
  end

  // Issue one access once the responder is idle, predict its outcome from
  // the reference memory, then scramble the inputs while it is in flight.
  task automatic apply_stimulus(input logic s_we, input logic [31:0] s_addr,
                                input logic [31:0] s_wdata);
    int         waited;
    exp_t       e;
    logic [5:0] idx;
    logic       mis;
    waited = 0;
    @(negedge clk);
    while (!(ready && exp_q.size() == 0) && waited < MAX_WAIT) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= MAX_WAIT) begin
      check_output("idle_timeout", {30'b0, ready, exp_q.size() == 0}, 32'd3);
      exp_q.delete();
    end
    idx = s_addr[7:2];
    mis = ALIGN_EN && (s_addr[1:0] != 2'b00);
    if (!mis) begin
      if (s_we) model_mem[idx] = s_wdata;
      else model_rdata = model_mem[idx];
    end
    e.exp_rdata   = model_rdata;
    e.exp_err     = mis;
    e.issue_cycle = cycle_cnt;
    exp_q.push_back(e);
    req   = 1'b1;
    we    = s_we;
    addr  = s_addr;
    wdata = s_wdata;
    @(negedge clk);
    req   = 1'b0;
    we    = 1'($urandom_range(0, 1));
    addr  = $urandom;
    wdata = $urandom;
  endtask

  initial begin : stimulus
    logic [31:0] saved;
    logic [31:0] r_addr;
    int          w;

    repeat (2) @(negedge clk);
    check_output("reset_ready", {31'b0, ready}, 32'd1);
    check_output("reset_done", {31'b0, done}, 32'd0);
    check_output("reset_err", {31'b0, err}, 32'd0);
    check_output("reset_rdata", rdata, 32'd0);
    check_output("reset_ready0", {31'b0, ready0}, 32'd1);
    rst = 1'b1;

    for (int i = 0; i < 64; i++) model_mem[i] = '0;
    for (int i = 0; i < 64; i++) apply_stimulus(1'b1, 32'(i * 4), 32'd0);

    apply_stimulus(1'b1, 32'h08, 32'hDEADBEEF);
    apply_stimulus(1'b0, 32'h08, 32'h0);
    apply_stimulus(1'b1, 32'h100, 32'hA5A5A5A5);
    apply_stimulus(1'b0, 32'h000, 32'h0);
    apply_stimulus(1'b1, 32'h0A, 32'hFF);
    apply_stimulus(1'b0, 32'h08, 32'h0);

    saved = model_mem[4];
    apply_stimulus(1'b1, 32'h10, 32'h55);
    #2 rst = 1'b0;
    #1;
    check_output("abort_ready", {31'b0, ready}, 32'd1);
    check_output("abort_done", {31'b0, done}, 32'd0);
    check_output("abort_err", {31'b0, err}, 32'd0);
    check_output("abort_rdata", rdata, 32'd0);
    exp_q.delete();
    model_mem[4] = saved;
    model_rdata  = '0;
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b0, 32'h10, 32'h0);

    repeat (150) begin
      r_addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
      apply_stimulus(1'($urandom_range(0, 1)), r_addr, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    w = 0;
    while (exp_q.size() != 0 && w < MAX_WAIT) begin
      @(negedge clk);
      w++;
    end
    check_output("drain", 32'(exp_q.size()), 32'd0);

    @(negedge clk);
    req0   = 1'b1;
    we0    = 1'b1;
    addr0  = 32'h04;
    wdata0 = 32'h1234;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_output($sformatf("wc0_done_%0d", k), {31'b0, done0}, (k % 2 == 1) ? 32'd1 : 32'd0);
      check_output($sformatf("wc0_ready_%0d", k), {31'b0, ready0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check_output($sformatf("wc0_err_%0d", k), {31'b0, err0}, 32'd0);
      if (k % 2 == 1 && k > 1) check_output($sformatf("wc0_rdata_%0d", k), rdata0, 32'h0000_1234);
      if (k == 1) begin
        we0    = 1'b0;
        wdata0 = $urandom;
      end
    end
    req0 = 1'b0;

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
